spmm_scheduler: RTL and testbench
=================================

Name: spmm_scheduler

Overview:
Top-level sequencer for one SPMM pass (H × W → WH).
- Accepts a row-major weight stream and distributes it into the per-column weight BRAMs, one BRAM per W column.
- Raises spmm_valid for the SPMM datapath.
- Counts WH BRAM write strobes until all H rows are produced, then signals done.
- Sits between the host/DMA loader and the SPMM block.

Parameters:
DATA_WIDTH, 8, weight element width
W_NUM_OF_ROWS, 1433, rows of W; depth of each column weight BRAM
W_NUM_OF_COLS, 16, columns of W; number of weight BRAMs / SP-PEs
H_NUM_OF_ROWS, 13264, WH rows expected per pass
WEIGHT_ADDR_W, $clog2(W_NUM_OF_ROWS), weight BRAM address width
ROW_CNT_W, $clog2(H_NUM_OF_ROWS+1), width of the WH row counter

Ports:
clk  in  1  single clock; all logic on posedge
rst_n  in  1  reset, synchronous, active-low
start_i  in  1  pass request; honoured only in IDLE
busy_o  out  1  high whenever state != IDLE
done_o  out  1  one-cycle pulse at end of pass
w_valid_i  in  1  weight stream beat valid
w_ready_o  out  1  scheduler accepts a weight beat
w_data_i  in  DATA_WIDTH  weight element; order W[r][c], c fastest
weight_wea_o  out  W_NUM_OF_COLS  one-hot write enable; bit c selects column BRAM c
weight_addra_o  out  WEIGHT_ADDR_W  shared write address (row r)
weight_din_o  out  DATA_WIDTH  shared write data
spmm_valid_o  out  1  drives SPMM spmm_valid_i
wh_wr_i  in  1  WH BRAM write strobe from SPMM (its WH_BRAM_wea)
rows_done_o  out  ROW_CNT_W  WH rows counted in the current/last pass

Behaviour:
- Reset: synchronous active-low; takes effect at the clock edge. Every output and internal counter goes to 0; state goes to IDLE. Reset mid-pass aborts the pass with no done_o.
- States:
  - IDLE → LOAD_W when start_i=1. This transition clears rows_done_o, col_cnt and row_cnt.
  - LOAD_W → ARM on acceptance of the final beat (row_cnt=W_NUM_OF_ROWS-1, col_cnt=W_NUM_OF_COLS-1).
  - ARM → RUN unconditionally after 1 cycle.
  - RUN → DONE on the counted wh_wr_i that brings rows_done to H_NUM_OF_ROWS.
  - DONE → IDLE unconditionally after 1 cycle.
- start_i outside IDLE is ignored; there is no queuing.
- w_ready_o = (state==LOAD_W), driven from the state register.
- Beat accept: w_valid_i & w_ready_o at an edge.
- Write path latency: 1 cycle. A beat accepted at edge t appears on the write ports during cycle t+1:
  - weight_wea_o = one-hot(col_cnt)
  - weight_addra_o = row_cnt
  - weight_din_o = w_data_i
- weight_wea_o is all-zero in every cycle not following an accept.
- Counters: col_cnt increments per accept and wraps W_NUM_OF_COLS-1 → 0. On that wrap, row_cnt increments. Both counters hold when no beat is accepted (valid gaps).
- ARM exists so the last weight write lands before the datapath reads weights. spmm_valid_o is registered and is high exactly while state==RUN; it first rises the cycle after the last weight write is visible.
- RUN counting:
  - Each cycle with wh_wr_i=1 increments rows_done_o by 1.
  - If wh_wr_i=1 while rows_done_o=H_NUM_OF_ROWS-1: rows_done_o becomes H_NUM_OF_ROWS, the state goes to DONE, and spmm_valid_o drops that same edge.
  - wh_wr_i is ignored in all states except RUN.
  - rows_done_o never exceeds H_NUM_OF_ROWS.
- done_o = (state==DONE), a single cycle; busy_o is still high in that cycle and low from the next.
- rows_done_o holds its final value in IDLE until the next accepted start_i.
- start_i asserted during DONE is ignored; it must be reasserted in IDLE.

Test Plan (bench params W_NUM_OF_ROWS=3, W_NUM_OF_COLS=4, H_NUM_OF_ROWS=5):
1. start, then 12 back-to-back beats with data 0..11:
   - Writes appear 1 cycle after each accept.
   - weight_wea_o cycles 0001, 0010, 0100, 1000 per row; weight_addra_o = 0, 0, 0, 0, 1, …, 2; weight_din_o = 0..11.
   - Exactly 12 write cycles.
   - spmm_valid_o rises 2 cycles after the final accept.
2. Beats with w_valid_i low on every other cycle → no weight_wea_o in gap cycles; address/column sequence identical to scenario 1.
3. In RUN, 5 wh_wr_i pulses with random gaps:
   - rows_done_o steps 1..5.
   - spmm_valid_o low the cycle after the 5th pulse.
   - done_o high for exactly 1 cycle; busy_o low the following cycle; rows_done_o stays 5.
4. start_i held high throughout a pass → no restart in LOAD_W/ARM/RUN/DONE; a new pass begins only on the first IDLE cycle.
5. wh_wr_i pulses during IDLE, LOAD_W and ARM → rows_done_o remains 0.
6. rst_n low for 1 cycle after 2 WH rows in RUN:
   - Next cycle all outputs are 0 and the state is IDLE; done_o is never pulsed.
   - A subsequent full pass completes normally with rows_done_o=5.

Source files
------------

// File: rtl/spmm_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : spmm_scheduler
//  Purpose  : Top-level sequencer for one SPMM pass (H x W -> WH).
//             Takes a row-major weight stream and scatters it into one
//             weight BRAM per W column. Raises spmm_valid for the SPMM
//             datapath, then counts WH BRAM write strobes until every H row
//             has been produced, and pulses done.
//  Revision : 1.0 - initial release
// ============================================================================
module spmm_scheduler #(
    parameter int DATA_WIDTH    = 8,
    parameter int W_NUM_OF_ROWS = 1433,
    parameter int W_NUM_OF_COLS = 16,
    parameter int H_NUM_OF_ROWS = 13264,
    parameter int WEIGHT_ADDR_W = $clog2(W_NUM_OF_ROWS),
    parameter int ROW_CNT_W     = $clog2(H_NUM_OF_ROWS + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,

    // pass control
    input  logic                     start_i,
    output logic                     busy_o,
    output logic                     done_o,

    // row-major weight stream, W[r][c] with c fastest
    input  logic                     w_valid_i,
    output logic                     w_ready_o,
    input  logic [DATA_WIDTH-1:0]    w_data_i,

    // per-column weight BRAM write port (address and data shared)
    output logic [W_NUM_OF_COLS-1:0] weight_wea_o,
    output logic [WEIGHT_ADDR_W-1:0] weight_addra_o,
    output logic [DATA_WIDTH-1:0]    weight_din_o,

    // SPMM datapath handshake
    output logic                     spmm_valid_o,
    input  logic                     wh_wr_i,
    output logic [ROW_CNT_W-1:0]     rows_done_o
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // Column counter is at least one bit wide so a single-column W still
    // elaborates cleanly.
    localparam int COL_CNT_W = (W_NUM_OF_COLS > 1) ? $clog2(W_NUM_OF_COLS) : 1;

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_LOAD_W = 3'd1;
    localparam logic [2:0] c_ARM    = 3'd2;
    localparam logic [2:0] c_RUN    = 3'd3;
    localparam logic [2:0] c_DONE   = 3'd4;

    localparam logic [COL_CNT_W-1:0]     c_LAST_COL = COL_CNT_W'(W_NUM_OF_COLS - 1);
    localparam logic [WEIGHT_ADDR_W-1:0] c_LAST_ROW = WEIGHT_ADDR_W'(W_NUM_OF_ROWS - 1);
    localparam logic [ROW_CNT_W-1:0]     c_LAST_WH  = ROW_CNT_W'(H_NUM_OF_ROWS - 1);
    localparam logic [W_NUM_OF_COLS-1:0] c_COL0_SEL = W_NUM_OF_COLS'(1);

    // ------------------------------------------------------------------------
    // State and counters
    // ------------------------------------------------------------------------
    logic [2:0]               r_state;
    logic [2:0]               w_state_nxt;

    logic [COL_CNT_W-1:0]     r_col_cnt;
    logic [WEIGHT_ADDR_W-1:0] r_row_cnt;
    logic [ROW_CNT_W-1:0]     r_rows_done;

    logic [W_NUM_OF_COLS-1:0] r_wea;
    logic [WEIGHT_ADDR_W-1:0] r_addra;
    logic [DATA_WIDTH-1:0]    r_din;
    logic                     r_spmm_valid;

    // ------------------------------------------------------------------------
    // Qualified events
    // ------------------------------------------------------------------------
    logic w_start;       // start request seen while idle
    logic w_accept;      // weight beat handshake completes this edge
    logic w_last_col;    // current beat targets the last column BRAM
    logic w_last_row;    // current beat targets the last weight row
    logic w_final_beat;  // current beat is the last element of W
    logic w_wh_count;    // WH write strobe that is counted
    logic w_wh_final;    // counted strobe that completes the pass

    assign w_start      = start_i & (r_state == c_IDLE);
    assign w_accept     = w_valid_i & (r_state == c_LOAD_W);
    assign w_last_col   = (r_col_cnt == c_LAST_COL);
    assign w_last_row   = (r_row_cnt == c_LAST_ROW);
    assign w_final_beat = w_accept & w_last_col & w_last_row;
    assign w_wh_count   = wh_wr_i & (r_state == c_RUN);
    assign w_wh_final   = w_wh_count & (r_rows_done == c_LAST_WH);

    // Next-state selection for the pass sequencer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:   if (w_start)      w_state_nxt = c_LOAD_W;
            c_LOAD_W: if (w_final_beat) w_state_nxt = c_ARM;
            // ARM gives the final weight write one cycle to land in its
            // BRAM before the datapath is allowed to read weights.
            c_ARM:                      w_state_nxt = c_RUN;
            c_RUN:    if (w_wh_final)   w_state_nxt = c_DONE;
            c_DONE:                     w_state_nxt = c_IDLE;
            default:                    w_state_nxt = c_IDLE;
        endcase
    end

    // State register; reset mid-pass simply abandons the pass.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Column/row position of the next weight beat; both hold across gaps.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_col_cnt <= '0;
            r_row_cnt <= '0;
        end else if (w_start) begin
            r_col_cnt <= '0;
            r_row_cnt <= '0;
        end else if (w_accept) begin
            if (w_last_col) begin
                r_col_cnt <= '0;
                // Wrap the row as well after the final element so the
                // counters never sit outside the BRAM depth.
                r_row_cnt <= w_last_row ? '0 : r_row_cnt + 1'b1;
            end else begin
                r_col_cnt <= r_col_cnt + 1'b1;
            end
        end
    end

    // Registered BRAM write port: one cycle after each accepted beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wea   <= '0;
            r_addra <= '0;
            r_din   <= '0;
        end else begin
            r_wea <= w_accept ? (c_COL0_SEL << r_col_cnt) : '0;
            if (w_accept) begin
                r_addra <= r_row_cnt;
                r_din   <= w_data_i;
            end
        end
    end

    // spmm_valid is registered from the next state so it tracks RUN exactly
    // and drops on the same edge that the last WH row is counted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_spmm_valid <= 1'b0;
        end else begin
            r_spmm_valid <= (w_state_nxt == c_RUN);
        end
    end

    // WH row counter: cleared on an accepted start, holds its final value
    // through DONE and IDLE so the host can read it back.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rows_done <= '0;
        end else if (w_start) begin
            r_rows_done <= '0;
        end else if (w_wh_count) begin
            r_rows_done <= r_rows_done + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign busy_o         = (r_state != c_IDLE);
    assign done_o         = (r_state == c_DONE);
    assign w_ready_o      = (r_state == c_LOAD_W);
    assign weight_wea_o   = r_wea;
    assign weight_addra_o = r_addra;
    assign weight_din_o   = r_din;
    assign spmm_valid_o   = r_spmm_valid;
    assign rows_done_o    = r_rows_done;

endmodule
`default_nettype wire

// File: tb/tb_spmm_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spmm_scheduler
//  Purpose  : Self-checking bench for spmm_scheduler (3x4 W, 5 WH rows).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spmm_scheduler;

    localparam int DW     = 8;
    localparam int R      = 3;
    localparam int C      = 4;
    localparam int H      = 5;
    localparam int AW     = $clog2(R);
    localparam int RW     = $clog2(H + 1);
    localparam int NBEATS = R * C;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_i = 1'b0;
    logic          w_valid_i = 1'b0;
    logic [DW-1:0] w_data_i = '0;
    logic          wh_wr_i = 1'b0;
    logic          busy_o, done_o, w_ready_o, spmm_valid_o;
    logic [C-1:0]  weight_wea_o;
    logic [AW-1:0] weight_addra_o;
    logic [DW-1:0] weight_din_o;
    logic [RW-1:0] rows_done_o;

    spmm_scheduler #(
        .DATA_WIDTH    (DW),
        .W_NUM_OF_ROWS (R),
        .W_NUM_OF_COLS (C),
        .H_NUM_OF_ROWS (H)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (start_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .w_valid_i      (w_valid_i),
        .w_ready_o      (w_ready_o),
        .w_data_i       (w_data_i),
        .weight_wea_o   (weight_wea_o),
        .weight_addra_o (weight_addra_o),
        .weight_din_o   (weight_din_o),
        .spmm_valid_o   (spmm_valid_o),
        .wh_wr_i        (wh_wr_i),
        .rows_done_o    (rows_done_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Table of beats with the BRAM write each must produce.
    typedef struct {
        int data;
        int exp_wea;
        int exp_addr;
        int exp_din;
    } vec_t;
    vec_t vecs[NBEATS];

    // Observed BRAM writes, captured mid-cycle.
    typedef struct {
        int wea;
        int addr;
        int din;
    } wr_t;
    wr_t wr_q[$];
    bit  mon_en = 1'b0;
    int  done_seen = 0;

    always @(negedge clk) begin
        if (mon_en && weight_wea_o != '0)
            wr_q.push_back('{int'(weight_wea_o), int'(weight_addra_o), int'(weight_din_o)});
        if (done_o) done_seen++;
    end

    // Reference model: pass phase (0 idle, 1 loading, 2 arming, 3 running,
    // 4 done), beats accepted so far and WH rows counted.
    int m_phase = 0;
    int m_beats = 0;
    int m_rows  = 0;
    bit m_wr    = 1'b0;
    int m_wr_col, m_wr_row, m_wr_data;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs held at that edge.
    task automatic model_edge();
        bit acc;
        if (!rst_n) begin
            m_phase = 0; m_beats = 0; m_rows = 0; m_wr = 1'b0;
            return;
        end
        acc  = (m_phase == 1) && w_valid_i;
        m_wr = acc;
        if (acc) begin
            m_wr_col  = m_beats % C;
            m_wr_row  = m_beats / C;
            m_wr_data = int'(w_data_i);
        end
        case (m_phase)
            0: if (start_i) begin m_phase = 1; m_beats = 0; m_rows = 0; end
            1: if (acc) begin
                   m_beats++;
                   if (m_beats == NBEATS) m_phase = 2;
               end
            2: m_phase = 3;
            3: if (wh_wr_i) begin
                   m_rows++;
                   if (m_rows == H) m_phase = 4;
               end
            default: m_phase = 0;
        endcase
    endtask

    task automatic check_model();
        chk("busy",       busy_o,       int'(m_phase != 0));
        chk("w_ready",    w_ready_o,    int'(m_phase == 1));
        chk("done",       done_o,       int'(m_phase == 4));
        chk("spmm_valid", spmm_valid_o, int'(m_phase == 3));
        chk("rows_done",  rows_done_o,  m_rows);
        chk("wea",        weight_wea_o, m_wr ? (1 << m_wr_col) : 0);
        if (m_wr) begin
            chk("addra", weight_addra_o, m_wr_row);
            chk("din",   weight_din_o,   m_wr_data);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        check_model();
    endtask

    task automatic compare_table(input string tag);
        chk({tag, "_write_count"}, wr_q.size(), NBEATS);
        for (int i = 0; i < NBEATS && i < wr_q.size(); i++) begin
            chk({tag, "_tbl_wea"},  wr_q[i].wea,  vecs[i].exp_wea);
            chk({tag, "_tbl_addr"}, wr_q[i].addr, vecs[i].exp_addr);
            chk({tag, "_tbl_din"},  wr_q[i].din,  vecs[i].exp_din);
        end
    endtask

    // Stream all beats; with gaps, a valid-low cycle precedes each beat.
    task automatic load_all(input bit gaps);
        for (int i = 0; i < NBEATS; i++) begin
            if (gaps) begin
                w_valid_i = 1'b0;
                w_data_i  = DW'($urandom);
                wh_wr_i   = 1'($urandom);
                step();
                chk("gap_wea", weight_wea_o, 0);
            end
            w_valid_i = 1'b1;
            w_data_i  = DW'(vecs[i].data);
            step();
        end
        w_valid_i = 1'b0;
        wh_wr_i   = 1'b0;
    endtask

    // Issue n WH strobes with random gaps, checking the count after each.
    task automatic run_rows(input int n, input int base);
        for (int k = 1; k <= n; k++) begin
            repeat ($urandom_range(0, 3)) step();
            wh_wr_i = 1'b1;
            step();
            wh_wr_i = 1'b0;
            chk("rows_step", rows_done_o, base + k);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0;
        for (int i = 0; i < NBEATS; i++)
            vecs[i] = '{i, 1 << (i % C), i / C, i};

        // Reset state
        rst_n = 1'b0;
        repeat (2) step();
        chk("rst_addra", weight_addra_o, 0);
        chk("rst_din",   weight_din_o,   0);
        rst_n = 1'b1;

        // WH strobes while idle are ignored
        wh_wr_i = 1'b1;
        repeat (2) step();
        wh_wr_i = 1'b0;
        chk("idle_wh_rows", rows_done_o, 0);

        // Back-to-back load
        wr_q.delete();
        mon_en  = 1'b1;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        load_all(1'b0);
        chk("arm_spmm_low", spmm_valid_o, 0);
        step();
        chk("run_spmm_high", spmm_valid_o, 1);
        mon_en = 1'b0;
        compare_table("b2b");

        // Row counting to completion
        run_rows(H, 0);
        chk("end_spmm_low", spmm_valid_o, 0);
        chk("end_done",     done_o,       1);
        chk("end_busy",     busy_o,       1);
        step();
        chk("post_done",  done_o,      0);
        chk("post_busy",  busy_o,      0);
        chk("post_rows",  rows_done_o, H);

        // Gapped load with WH strobes during LOAD_W and ARM
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        wr_q.delete();
        mon_en = 1'b1;
        load_all(1'b1);
        wh_wr_i = 1'b1;
        step();
        wh_wr_i = 1'b0;
        mon_en = 1'b0;
        chk("arm_wh_rows", rows_done_o, 0);
        compare_table("gap");
        run_rows(H, 0);
        step();

        // start_i held high across a whole pass
        start_i = 1'b1;
        step();
        load_all(1'b0);
        step();
        run_rows(H, 0);
        chk("held_done", done_o, 1);
        step();
        chk("held_idle_busy", busy_o, 0);
        step();
        chk("held_restart", w_ready_o, 1);
        start_i = 1'b0;

        // Reset after two WH rows
        load_all(1'b0);
        step();
        run_rows(2, 0);
        d0 = done_seen;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mid_rst_busy",  busy_o,         0);
        chk("mid_rst_spmm",  spmm_valid_o,   0);
        chk("mid_rst_rows",  rows_done_o,    0);
        chk("mid_rst_wea",   weight_wea_o,   0);
        chk("mid_rst_addra", weight_addra_o, 0);
        chk("mid_rst_din",   weight_din_o,   0);
        step();
        chk("mid_rst_no_done", done_seen, d0);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        load_all(1'b0);
        step();
        run_rows(H, 0);
        step();
        chk("after_rst_rows", rows_done_o, H);
        chk("after_rst_done_pulses", done_seen, d0 + 1);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst_n     = ($urandom_range(0, 299) != 0);
            start_i   = ($urandom_range(0, 3) == 0);
            w_valid_i = 1'($urandom);
            w_data_i  = DW'($urandom);
            wh_wr_i   = ($urandom_range(0, 2) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
